mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin controller that shares one 4:1 data mux between four requesters.
- Arbitrates the req lines, holds a grant while the owner keeps req high (bounded by MAX_HOLD), and drives the mux select.
- Gates the mux output with a valid flag.
- Sits in front of the 4:1 mux datapath; the mux itself is instantiated inside the block.

Parameters:
- DATA_W, 1: width of each data input and of y.
- MAX_HOLD, 8: maximum consecutive cycles one grant may last; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- d0  input  DATA_W  requester 0 data.
- d1  input  DATA_W  requester 1 data.
- d2  input  DATA_W  requester 2 data.
- d3  input  DATA_W  requester 3 data.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select {s1,s0}, registered; encodes the granted index.
- valid  output  1  high while any gnt bit is high.
- y  output  DATA_W  selected data, combinational from d[sel] when valid, else 0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - gnt=0, sel=0, valid=0, y=0.
  - state=IDLE, hold counter=0, priority pointer ptr=0.
  - Applies immediately, including mid-grant; the grant is lost and not resumed.
- State IDLE:
  - If req==0, remain in IDLE.
  - Otherwise, on the next edge, grant the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Set gnt to that bit, sel to its index, valid=1, clear the counter, go to BUSY.
  - Latency from req seen in IDLE to gnt: 1 cycle.
- State BUSY:
  - Counter increments each cycle; the grant cycle counts as cycle 1.
  - Release condition: req[sel]==0, or counter==MAX_HOLD.
  - On release, on the next edge: gnt=0, valid=0, ptr=sel+1 (mod 4), go to IDLE.
  - sel keeps its last value during IDLE.
  - Otherwise gnt, sel and valid are held.
- Mandatory gap: at least one IDLE cycle (valid=0) between any two grants, including back-to-back grants to different requesters.
- MAX_HOLD=1: every grant lasts exactly one cycle, followed by one IDLE cycle.
- req changes on non-owner bits during BUSY are ignored until IDLE.
- Requester-side rule: a requester drops req only after seeing its gnt bit or giving up. If req deasserts before the grant edge in IDLE, it is simply not considered.
- y = d[sel] when valid=1, else all zeros.
  - sel→d mapping: 0→d0, 1→d1, 2→d2, 3→d3.
- Invariants:
  - gnt is one-hot or zero.
  - valid == |gnt.
  - When valid=1, gnt[sel]=1.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, req=0000 for 5 cycles -> gnt=0000, sel=00, valid=0, y=0 throughout.
2. Single requester: req=0100, d2=1, others 0 -> gnt=0100 one cycle after req, sel=10, y=1. Drop req after 3 grant cycles -> next cycle gnt=0000, ptr=3.
3. Round-robin fairness: req=1111 held, MAX_HOLD=2 -> grant sequence r0,r1,r2,r3,r0. Each grant lasts 2 cycles, separated by 1 IDLE cycle; sel follows 00,01,10,11,00.
4. Hold timeout: req=0001 held 20 cycles, MAX_HOLD=8 -> grant cycles 1-8, gap, then re-grant to r0 (only requester), repeating.
5. Async reset mid-grant: during BUSY with gnt=0010, pulse rst_n low between edges -> gnt, sel, valid drop immediately without a clock. After release with req=1111 -> first grant goes to r0 (ptr=0).
6. Pointer wrap plus non-owner noise: grant r3 released -> ptr=0. With req=1010 the next winner is r1. Toggling req[3] during r1's BUSY does not alter gnt.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters.
// A grant is held while its owner keeps req high, up to MAX_HOLD cycles, and is always followed by an idle cycle.
module mux4_rr_arbiter #(
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              valid,
  output logic [DATA_W-1:0] y
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] HOLD = 8'(MAX_HOLD);

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        win_found;
  logic [1:0]  win_idx;
  logic [1:0]  probe;
  logic [DATA_W-1:0] mux_out;

  // First set request found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    probe     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      probe = ptr_q + 2'(i);
      if (!win_found && req[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = 4'b0001 << win_idx;
          sel_d   = win_idx;
          // The grant cycle itself is hold cycle 1.
          cnt_d   = 8'd1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req[sel_q] || (cnt_q == HOLD)) begin
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mux_out = '0;
    unique case (sel_q)
      2'd0:    mux_out = d0;
      2'd1:    mux_out = d1;
      2'd2:    mux_out = d2;
      2'd3:    mux_out = d3;
      default: mux_out = '0;
    endcase
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;
  assign y     = valid ? mux_out : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: three instances (MAX_HOLD 8, 2, 1) share one stimulus stream.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] dv;

  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       valid_a, valid_b, valid_c;
  logic       y_a, y_b, y_c;

  int n_assert;
  int n_fail;

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(8)) u_h8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .gnt(gnt_a), .sel(sel_a), .valid(valid_a), .y(y_a)
  );

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .gnt(gnt_b), .sel(sel_b), .valid(valid_b), .y(y_b)
  );

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
    .gnt(gnt_c), .sel(sel_c), .valid(valid_c), .y(y_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [7:0] obs_a = {gnt_a, sel_a, valid_a, y_a};
  wire [7:0] obs_b = {gnt_b, sel_b, valid_b, y_b};
  wire [7:0] obs_c = {gnt_c, sel_c, valid_c, y_c};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed {gnt,sel,valid,y}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Expected outputs k cycles after a steady request pattern starts from IDLE with ptr=0.
  function automatic logic [7:0] exp_rr(input int unsigned h, input int unsigned k, input bit rotate);
    int unsigned idx;
    logic [3:0]  g;
    idx = rotate ? ((k / (h + 1)) % 4) : 0;
    g   = 4'b0001 << idx;
    if ((k % (h + 1)) < h) return {g, 2'(idx), 1'b1, dv[idx]};
    else                   return {4'b0000, 2'(idx), 1'b0, 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("rst_a", obs_a, 8'h00);
    chk("rst_b", obs_b, 8'h00);
    chk("rst_c", obs_c, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    dv       = 4'b0000;

    // Reset held three cycles, then idle with no requests.
    repeat (3) begin
      @(negedge clk);
      chk("t1_in_reset", obs_a, 8'h00);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t1_idle", obs_a, 8'h00);
    end

    // Single requester r2, held three grant cycles.
    dv  = 4'b0100;
    req = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      chk("t2_grant_r2", obs_a, {4'b0100, 2'd2, 1'b1, 1'b1});
    end
    req = 4'b0000;
    @(negedge clk);
    chk("t2_release", obs_a, {4'b0000, 2'd2, 1'b0, 1'b0});
    req = 4'b1111;
    @(negedge clk);
    chk("t2_ptr_is_3", obs_a, {4'b1000, 2'd3, 1'b1, 1'b0});

    // r3 released -> ptr wraps to 0; r1 wins over r3; req[3] noise ignored.
    req = 4'b0000;
    @(negedge clk);
    chk("t6_gap", obs_a, {4'b0000, 2'd3, 1'b0, 1'b0});
    dv  = 4'b0010;
    req = 4'b1010;
    @(negedge clk);
    chk("t6_r1_wins", obs_a, {4'b0010, 2'd1, 1'b1, 1'b1});
    req = 4'b0010;
    @(negedge clk);
    chk("t6_noise_lo", obs_a, {4'b0010, 2'd1, 1'b1, 1'b1});
    req = 4'b1010;
    @(negedge clk);
    chk("t6_noise_hi", obs_a, {4'b0010, 2'd1, 1'b1, 1'b1});
    req = 4'b1000;
    @(negedge clk);
    chk("t6_r1_release", obs_a, {4'b0000, 2'd1, 1'b0, 1'b0});
    @(negedge clk);
    chk("t6_r3_next", obs_a, {4'b1000, 2'd3, 1'b1, 1'b0});

    // Asynchronous reset pulse between edges during r1's grant.
    do_reset();
    dv  = 4'b0010;
    req = 4'b0010;
    @(negedge clk);
    chk("t5_busy_r1", obs_a, {4'b0010, 2'd1, 1'b1, 1'b1});
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_a", obs_a, 8'h00);
    chk("t5_async_b", obs_b, 8'h00);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    chk("t5_ptr_reset", obs_a, {4'b0001, 2'd0, 1'b1, 1'b0});

    // Round-robin with all requesting: hold 8, 2 and 1.
    do_reset();
    dv  = 4'b1101;
    req = 4'b1111;
    for (int unsigned k = 0; k < 13; k++) begin
      @(negedge clk);
      chk("t3_rr_h8", obs_a, exp_rr(8, k, 1'b1));
      chk("t3_rr_h2", obs_b, exp_rr(2, k, 1'b1));
      chk("t3_rr_h1", obs_c, exp_rr(1, k, 1'b1));
    end

    // Hold timeout with a single persistent requester.
    do_reset();
    dv  = 4'b0001;
    req = 4'b0001;
    for (int unsigned k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t4_hold_h8", obs_a, exp_rr(8, k, 1'b0));
      chk("t4_hold_h2", obs_b, exp_rr(2, k, 1'b0));
      chk("t4_hold_h1", obs_c, exp_rr(1, k, 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
